lifo_arbiter: RTL

- Round-robin arbiter that shares one LIFO stack between NUM_REQ requesters.
- Each requester issues push or pop requests; at most one stack operation is granted per cycle.
- Pop data returns one cycle later, tagged with the requester ID.
- Sits between client blocks and the LIFO; it is the only driver of the LIFO read/write/dataIn pins.

---
 rtl/lifo_arb_pkg.sv | 19 +
 rtl/lifo_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/lifo_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// Shared types and helpers for the round-robin LIFO arbiter.
package lifo_arb_pkg;

   localparam int unsigned NUM_REQ_DEF = 2;
   localparam int unsigned WIDTH_DEF   = 8;
   localparam int unsigned ID_W_DEF    = 3;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2
   } op_e;

   // Index that follows idx in a ring of n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/lifo_arbiter_if.sv
// Client-side request/response bundle of the LIFO arbiter.
interface lifo_arbiter_if
   import lifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned ID_W    = ID_W_DEF
) ();

   logic [NUM_REQ-1:0]       req_push;
   logic [NUM_REQ-1:0]       req_pop;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       grant;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_data;

   modport master (
      output req_push, req_pop, req_data,
      input  grant, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_push, req_pop, req_data,
      output grant, rsp_valid, rsp_id, rsp_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches from the slot after the last winner and
// remembers the winner only on cycles that actually grant.
module rr_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int unsigned N     = NUM_REQ_DEF,
   parameter int unsigned IDX_W = ID_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     elig,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] last_grant_q;
   logic [IDX_W-1:0] last_grant_d;
   int unsigned      start;
   logic             found;

   // Two passes: first from start to the top, then wrap to index 0.
   always_comb begin
      gnt          = '0;
      gnt_idx      = '0;
      found        = 1'b0;
      start        = rr_next(32'(last_grant_q), N);
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && elig[i] && i >= start) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && elig[i]) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
      last_grant_d = found ? gnt_idx : last_grant_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= IDX_W'(N - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between NUM_REQ clients: one push or pop per cycle,
// pop data returned the following cycle tagged with the owner's index.
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned ID_W    = ID_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   lifo_arbiter_if.slave    bus,
   output logic             stack_write,
   output logic             stack_read,
   output logic [WIDTH-1:0] stack_din,
   input  logic [WIDTH-1:0] stack_dout,
   input  logic             stack_full,
   input  logic             stack_empty
);

   op_e              op [NUM_REQ];
   op_e              win_op;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;

   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic             rsp_fire;

   // Push dominates pop per requester; flags gate eligibility, reset blocks all.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         op[i] = OP_NONE;
         if (bus.req_push[i]) begin
            op[i] = OP_PUSH;
         end else if (bus.req_pop[i]) begin
            op[i] = OP_POP;
         end
         elig[i] = (op[i] == OP_PUSH && !stack_full) ||
                   (op[i] == OP_POP  && !stack_empty);
      end
      if (reset) begin
         elig = '0;
      end
   end

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr (
      .clk     (clk),
      .reset   (reset),
      .elig    (elig),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      win_op    = OP_NONE;
      stack_din = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            win_op = op[i];
            if (op[i] == OP_PUSH) begin
               stack_din = bus.req_data[i*WIDTH +: WIDTH];
            end
         end
      end
      stack_write = (win_op == OP_PUSH);
      stack_read  = (win_op == OP_POP);
   end

   assign bus.grant = gnt;

   always_comb begin
      rsp_valid_d = stack_read;
      rsp_id_d    = gnt_idx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   // A reset cycle kills a response already in flight from the prior grant.
   assign rsp_fire      = rsp_valid_q && !reset;
   assign bus.rsp_valid = rsp_fire;
   assign bus.rsp_id    = rsp_fire ? rsp_id_q : '0;
   assign bus.rsp_data  = rsp_fire ? stack_dout : '0;

endmodule
